// File: rtl/spi_responder.sv
// SPI responder: 8-bit MSB-first frames counted on sck edges, TX FIFO push port, RX byte strobe.
// Optional: define SPI_RESPONDER_ECHO_EN to echo the completed RX byte when the TX FIFO runs dry.
module spi_responder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic                          sck,
  input  logic                          rst,
  input  logic                          mosi,
  output logic                          miso,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          underrun,
  output logic [2:0]                    bit_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_tx_ready;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_tx_shift;
  logic [6:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_underrun;

  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_boundary;
  logic [7:0]  w_rx_byte;
  logic [7:0]  w_dry_byte;
  logic [AW:0] w_wr_next;
  logic [AW:0] w_rd_next;
  logic        w_full_next;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  // tx_ready is the pre-edge !full, so a same-edge pop never admits a push into a full FIFO
  assign w_push     = tx_valid && r_tx_ready;
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_pop      = w_boundary && !w_empty;
  assign w_rx_byte  = {r_rx_shift, mosi};
  assign w_wr_next  = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_next  = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_full_next = (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]) &&
                       (w_wr_next[AW] != w_rd_next[AW]);

`ifdef SPI_RESPONDER_ECHO_EN
  assign w_dry_byte = w_rx_byte;
`else
  assign w_dry_byte = FILL_BYTE;
`endif

  always_ff @(posedge sck) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge sck) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tx_ready <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_tx_shift <= FILL_BYTE;
      r_rx_shift <= 7'd0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_next;
      r_rd_ptr   <= w_rd_next;
      r_tx_ready <= !w_full_next;
      r_rx_valid <= 1'b0;
      if (w_boundary) begin
        r_bit_cnt  <= 3'd0;
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
        r_rx_shift <= w_rx_byte[6:0];
        if (!w_empty) begin
          r_tx_shift <= r_mem[r_rd_ptr[AW-1:0]];
        end else begin
          r_tx_shift <= w_dry_byte;
          r_underrun <= 1'b1;
        end
      end else begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_rx_shift <= w_rx_byte[6:0];
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  assign miso     = r_tx_shift[7];
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_level = r_wr_ptr - r_rd_ptr;
  assign underrun = r_underrun;
  assign bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: directed scenarios plus random traffic against a frame-level model.
module tb_spi_responder;
  localparam int         DEPTH = 4;
  localparam logic [7:0] FILL  = 8'hFF;

  logic       sck = 1'b0;
  logic       rst = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] tx_level;
  logic       underrun;
  logic [2:0] bit_cnt;

  spi_responder #(.FIFO_DEPTH(DEPTH), .FILL_BYTE(FILL)) dut (
    .sck(sck), .rst(rst), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_level(tx_level),
    .underrun(underrun), .bit_cnt(bit_cnt)
  );

  always #5 sck = ~sck;

  int total = 0;
  int bad = 0;

  // Frame-level model: queue of pending bytes, byte on the wire, bit position in the frame
  logic [7:0] m_q[$];
  logic [7:0] m_cur = FILL;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_rxd = 8'h00;
  int         m_pos = 0;
  logic       m_rxv = 1'b0;
  logic       m_und = 1'b0;
  logic       m_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic m, input logic v, input logic [7:0] d);
    logic acc;
    rst = r; mosi = m; tx_valid = v; tx_data = d;
    @(posedge sck);
    if (!r) begin
      m_q.delete();
      m_pos = 0; m_cur = FILL; m_acc = 8'h00; m_rxd = 8'h00;
      m_rxv = 1'b0; m_und = 1'b0; m_rdy = 1'b0;
    end else begin
      acc   = v && m_rdy;
      m_acc = {m_acc[6:0], m};
      m_rxv = 1'b0;
      if (m_pos == 7) begin
        m_rxd = m_acc;
        m_rxv = 1'b1;
        m_pos = 0;
        if (m_q.size() > 0) m_cur = m_q.pop_front();
        else begin
          m_und = 1'b1;
`ifdef SPI_RESPONDER_ECHO_EN
          m_cur = m_acc;
`else
          m_cur = FILL;
`endif
        end
      end else begin
        m_pos++;
      end
      if (acc) m_q.push_back(d);
      m_rdy = (m_q.size() < DEPTH);
    end
    @(negedge sck);
    check("miso", miso, m_cur[7-m_pos]);
    check("bit_cnt", bit_cnt, m_pos);
    check("rx_valid", rx_valid, m_rxv);
    check("rx_data", rx_data, m_rxd);
    check("tx_level", tx_level, m_q.size());
    check("tx_ready", tx_ready, m_rdy);
    check("underrun", underrun, m_und);
  endtask

  task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 0; i < 8; i++) begin
      mi[7-i] = miso;
      step(1'b1, mo[7-i], 1'b0, 8'h00);
    end
  endtask

  logic [7:0] mi;

  initial begin
    @(negedge sck);
    // Reset state
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_ready", tx_ready, 0);
    check("rst_miso", miso, FILL[7]);
    check("rst_level", tx_level, 0);

    // First frame after reset: fill byte out, A5 in, underrun
    frame(8'hA5, mi);
    check("f0_miso", mi, 8'hFF);
    check("f0_rxv", rx_valid, 1);
    check("f0_rxd", rx_data, 8'hA5);
    check("f0_und", underrun, 1);

    // Two queued bytes drain over frames 1 and 2, underrun at the end of frame 2
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      mi[7-i] = miso;
      step(1'b1, 1'b1, (i == 1 || i == 2), (i == 1) ? 8'h3C : 8'hC3);
      if (i == 2) check("q_lvl2", tx_level, 2);
    end
    check("q_f0", mi, 8'hFF);
    check("q_lvl1", tx_level, 1);
    frame(8'hFF, mi);
    check("q_f1", mi, 8'h3C);
    check("q_lvl0", tx_level, 0);
    check("q_und0", underrun, 0);
    frame(8'hFF, mi);
    check("q_f2", mi, 8'hC3);
    check("q_und1", underrun, 1);

    // Overfill, then pop with a concurrent push into a full FIFO
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b1, 8'(i * 8'h11));
    check("full_lvl", tx_level, 4);
    check("full_rdy", tx_ready, 0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h66);
    check("full_pop_lvl", tx_level, 3);
    frame(8'h00, mi);
    check("full_f1", mi, 8'h11);

    // Push on the boundary edge into an empty FIFO
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    frame(8'h00, mi);
    check("bnd_f1", mi, 8'hFF);
    frame(8'h00, mi);
    check("bnd_f2", mi, 8'h5A);

    // Reset mid-frame at bit_cnt 4
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h81);
    step(1'b1, 1'b1, 1'b1, 8'h82);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("mid_bc4", bit_cnt, 4);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("mid_rxv", rx_valid, 0);
    check("mid_lvl", tx_level, 0);
    check("mid_miso", miso, FILL[7]);
    check("mid_bc", bit_cnt, 0);

`ifdef SPI_RESPONDER_ECHO_EN
    frame(8'h12, mi);
    check("echo_f1", mi, 8'hFF);
    frame(8'h34, mi);
    check("echo_f2", mi, 8'h12);
    frame(8'h00, mi);
    check("echo_f3", mi, 8'h34);
`endif

    // Random traffic with occasional resets
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
           8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
